// File: rtl/ddp_pkg.sv
// Shared defaults and SubPS entry layout for the data-driven pipeline stages.
// Entry layout: [0] = MF, [SEL_W:1] = port_f, [2*SEL_W:SEL_W+1] = port_t.
package ddp_pkg;

    localparam int unsigned PKT_W_DEFAULT    = 38;
    localparam int unsigned DEST_LSB_DEFAULT = 20;
    localparam int unsigned ADDR_W_DEFAULT   = 6;
    localparam int unsigned BR_BIT_DEFAULT   = 18;

    localparam int unsigned MF_BIT     = 0;
    localparam int unsigned PORT_F_LSB = 1;

    function automatic int unsigned port_t_lsb(input int unsigned sel_w);
        return 1 + sel_w;
    endfunction

    function automatic int unsigned ent_width(input int unsigned sel_w);
        return 1 + 2 * sel_w;
    endfunction

endpackage

// File: rtl/subps_ram.sv
// SubPS register file: one synchronous read port, one write port with
// read-before-write behaviour, synchronous clear of every entry on reset.
module subps_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned ENT_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [ENT_W-1:0]  rd_data_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [ENT_W-1:0]  wr_data_i
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] rd_data_q;

    // Read and write share the edge; non-blocking update gives the old entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (rd_en_i) begin
                rd_data_q <= mem_q[rd_addr_i];
            end
            if (we_i) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/b_stage_sync.sv
// Branch stage: S1 looks up the SubPS entry for the packet's destination,
// S2 holds the merged packet and steers it to one of NOUT Send/Ack channels.
module b_stage_sync
    import ddp_pkg::*;
#(
    parameter int unsigned PKT_W    = PKT_W_DEFAULT,
    parameter int unsigned DEST_LSB = DEST_LSB_DEFAULT,
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
    parameter int unsigned BR_BIT   = BR_BIT_DEFAULT,
    parameter int unsigned NOUT     = 2,
    localparam int unsigned SEL_W   = $clog2(NOUT),
    localparam int unsigned ENT_W   = ent_width(SEL_W)
) (
    input  logic              CP,
    input  logic              MR,
    input  logic [PKT_W-1:0]  PACKET_IN,
    input  logic              Send_in,
    output logic              Ack_out,
    output logic [PKT_W-1:0]  PACKET_OUT,
    output logic [NOUT-1:0]   Send_out,
    input  logic [NOUT-1:0]   Ack_in,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [ENT_W-1:0]  cfg_data,
    output logic              route_err
);

    localparam int unsigned    PT_LSB = port_t_lsb(SEL_W);
    localparam logic [SEL_W:0] NOUT_W = (SEL_W + 1)'(NOUT);

    logic             s1_valid_q, s2_valid_q, route_err_q;
    logic [PKT_W-1:0] s1_pkt_q, s2_pkt_q;
    logic [SEL_W-1:0] s2_port_q;

    logic [ENT_W-1:0] entry;
    logic [SEL_W-1:0] sel_port, s1_port;
    logic [PKT_W-1:0] merged;
    logic             s1_err, accept, s1_move, s2_move;

    assign accept = Send_in && Ack_out;

    subps_ram #(
        .ADDR_W (ADDR_W),
        .ENT_W  (ENT_W)
    ) u_subps_ram (
        .clk_i     (CP),
        .rst_i     (MR),
        .rd_en_i   (accept),
        .rd_addr_i (PACKET_IN[DEST_LSB +: ADDR_W]),
        .rd_data_o (entry),
        .we_i      (cfg_we),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_data)
    );

    always_comb begin
        sel_port = s1_pkt_q[BR_BIT] ? entry[PT_LSB +: SEL_W] : entry[PORT_F_LSB +: SEL_W];
        // Only reachable for non-power-of-two NOUT; such packets fall back to port 0.
        s1_err   = {1'b0, sel_port} >= NOUT_W;
        s1_port  = s1_err ? '0 : sel_port;
        merged         = s1_pkt_q;
        merged[BR_BIT] = entry[MF_BIT];

        s2_move = s2_valid_q && Ack_in[s2_port_q];
        s1_move = s1_valid_q && (!s2_valid_q || s2_move);
        Ack_out = !s1_valid_q || s1_move;

        Send_out = '0;
        if (s2_valid_q) begin
            Send_out[s2_port_q] = 1'b1;
        end
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s1_pkt_q    <= '0;
            s2_pkt_q    <= '0;
            s2_port_q   <= '0;
            route_err_q <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_pkt_q   <= PACKET_IN;
            end else if (s1_move) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_move) begin
                s2_valid_q <= 1'b1;
                s2_pkt_q   <= merged;
                s2_port_q  <= s1_port;
            end else if (s2_move) begin
                s2_valid_q <= 1'b0;
            end

            route_err_q <= s1_move && s1_err;
        end
    end

    assign PACKET_OUT = s2_pkt_q;
    assign route_err  = route_err_q;

endmodule

// File: tb/tb_b_stage_sync.sv
// Scoreboard bench for b_stage_sync: default NOUT=2 instance under random and
// directed traffic, plus a NOUT=3 instance for the out-of-range port case.
module tb_b_stage_sync;

    logic CP = 1'b0;
    always #5 CP = ~CP;

    logic        MR;
    logic [37:0] pkt_in, pkt_out;
    logic        send_in, ack_out, cfg_we, route_err;
    logic [1:0]  send_out, ack_in;
    logic [5:0]  cfg_addr;
    logic [2:0]  cfg_data;

    logic [37:0] p3_in, p3_out;
    logic        s3_in, a3_out, w3, err3;
    logic [2:0]  s3_out, a3_in;
    logic [5:0]  addr3;
    logic [4:0]  data3;

    b_stage_sync dut (
        .CP         (CP),
        .MR         (MR),
        .PACKET_IN  (pkt_in),
        .Send_in    (send_in),
        .Ack_out    (ack_out),
        .PACKET_OUT (pkt_out),
        .Send_out   (send_out),
        .Ack_in     (ack_in),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .route_err  (route_err)
    );

    b_stage_sync #(.NOUT(3)) dut3 (
        .CP         (CP),
        .MR         (MR),
        .PACKET_IN  (p3_in),
        .Send_in    (s3_in),
        .Ack_out    (a3_out),
        .PACKET_OUT (p3_out),
        .Send_out   (s3_out),
        .Ack_in     (a3_in),
        .cfg_we     (w3),
        .cfg_addr   (addr3),
        .cfg_data   (data3),
        .route_err  (err3)
    );

    typedef struct {
        logic [37:0] pkt;
        int          port;
        int          acc;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] tbl [64];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    bit         mvis;
    logic [1:0] mexp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [37:0] mkpkt(input int dest, input bit br);
        logic [63:0] r;
        logic [37:0] p;
        r = {$urandom(), $urandom()};
        p = r[37:0];
        p[25:20] = 6'(dest);
        p[18] = br;
        return p;
    endfunction

    // A packet accepted at an edge is in S1 for one cycle, then visible from S2.
    always @(negedge CP) begin
        if (mon_en) begin
            mvis = sb.size() > 0 && cyc >= sb[0].acc + 1;
            mexp = mvis ? (2'b01 << sb[0].port) : 2'b00;
            chk("send_out", 64'(send_out), 64'(mexp));
            if (mvis) chk("packet_out", 64'(pkt_out), 64'(sb[0].pkt));
            chk("route_err", 64'(route_err), 64'd0);
            chk("ack_out", 64'(ack_out), 64'((sb.size() < 2) || ack_in[sb[0].port]));
            if (mvis && ack_in[sb[0].port]) void'(sb.pop_front());
        end
        cyc++;
    end

    // One cycle: drive at posedge+1, decide at negedge, update the model at posedge.
    task automatic step(input logic [37:0] p, input logic snd, input logic [1:0] ack,
                        input logic we, input logic [5:0] a, input logic [2:0] d,
                        input logic mr, output logic acc);
        exp_t       e;
        logic [2:0] ent;
        pkt_in = p; send_in = snd; ack_in = ack;
        cfg_we = we; cfg_addr = a; cfg_data = d; MR = mr;
        @(negedge CP);
        acc = snd && ack_out && !mr;
        ent = tbl[p[25:20]];
        e.pkt = p;
        e.pkt[18] = ent[0];
        e.port = p[18] ? int'(ent[2]) : int'(ent[1]);
        @(posedge CP);
        if (mr) begin
            sb.delete();
            for (int i = 0; i < 64; i++) tbl[i] = 3'b000;
        end else begin
            if (acc) begin
                e.acc = cyc;
                sb.push_back(e);
            end
            if (we) tbl[a] = d;
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step('0, 1'b0, 2'b11, 1'b0, '0, '0, 1'b0, acc);
    endtask

    task automatic send1(input logic [37:0] p);
        logic acc;
        int   k;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 20) begin
            step(p, 1'b1, 2'b11, 1'b0, '0, '0, 1'b0, acc);
            k++;
        end
        chk("accept_bound", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 20) begin
            idle(1);
            k++;
        end
        idle(1);
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic        acc;
        logic [37:0] pk [3];
        logic [37:0] cur, e3;
        int          i;

        s3_in = 1'b0; a3_in = 3'b111; w3 = 1'b0; addr3 = '0; data3 = '0; p3_in = '0;
        @(posedge CP);
        #1;
        step('0, 1'b0, 2'b00, 1'b1, 6'd1, 3'b111, 1'b1, acc);
        step('0, 1'b0, 2'b00, 1'b0, '0, '0, 1'b1, acc);
        MR = 1'b0;
        send_in = 1'b0;
        mon_en = 1'b1;
        chk("rst_send_out", 64'(send_out), 64'd0);
        chk("rst_ack_out", 64'(ack_out), 64'd1);
        chk("rst_packet_out", 64'(pkt_out), 64'd0);
        chk("rst_route_err", 64'(route_err), 64'd0);
        chk("rst3_send_out", 64'(s3_out), 64'd0);
        chk("rst3_ack_out", 64'(a3_out), 64'd1);

        // Default table: everything on port 0 with MF cleared.
        send1(mkpkt(5, 1'b1));
        drain();

        step('0, 1'b0, 2'b11, 1'b1, 6'd7, 3'b101, 1'b0, acc);
        send1(mkpkt(7, 1'b1));
        send1(mkpkt(7, 1'b0));
        drain();

        // Backpressure on port 1: two fill the stage, the third waits.
        for (int k = 0; k < 3; k++) pk[k] = mkpkt(7, 1'b1);
        i = 0;
        for (int c = 0; c < 5; c++) begin
            step(pk[i], 1'b1, 2'b00, 1'b0, '0, '0, 1'b0, acc);
            if (acc) i++;
        end
        chk("bp_accepted", 64'(i), 64'd2);
        chk("bp_ack_out", 64'(ack_out), 64'd0);
        for (int c = 0; c < 10 && i < 3; c++) begin
            step(pk[i], 1'b1, 2'b10, 1'b0, '0, '0, 1'b0, acc);
            if (acc) i++;
        end
        chk("bp_third", 64'(i), 64'd3);
        drain();

        // Lookup and write to the same index on the same edge.
        step(mkpkt(3, 1'b0), 1'b1, 2'b11, 1'b1, 6'd3, 3'b001, 1'b0, acc);
        chk("same_edge_accept", 64'(acc), 64'd1);
        send1(mkpkt(3, 1'b0));
        drain();

        // Reset with both stages full.
        i = 0;
        for (int c = 0; c < 4; c++) begin
            step(mkpkt(7, 1'b1), 1'b1, 2'b00, 1'b0, '0, '0, 1'b0, acc);
            if (acc) i++;
        end
        chk("mr_fill", 64'(i), 64'd2);
        step(mkpkt(7, 1'b1), 1'b1, 2'b00, 1'b1, 6'd7, 3'b111, 1'b1, acc);
        send_in = 1'b0;
        MR = 1'b0;
        chk("mr_send_out", 64'(send_out), 64'd0);
        chk("mr_ack_out", 64'(ack_out), 64'd1);
        send1(mkpkt(7, 1'b1));
        drain();

        // Random traffic, config writes and occasional resets.
        cur = mkpkt($urandom_range(0, 7), 1'($urandom()));
        for (int c = 0; c < 400; c++) begin
            step(cur, 1'($urandom_range(0, 3) != 0), 2'($urandom()),
                 1'($urandom_range(0, 3) == 0), 6'($urandom_range(0, 7)), 3'($urandom()),
                 1'($urandom_range(0, 63) == 0), acc);
            if (acc) cur = mkpkt($urandom_range(0, 7), 1'($urandom()));
        end
        drain();

        // NOUT=3: port_t=3 is out of range and must fall back to port 0.
        w3 = 1'b1; addr3 = 6'd9; data3 = 5'b11000;
        idle(1);
        w3 = 1'b0;
        p3_in = mkpkt(9, 1'b1);
        e3 = p3_in;
        e3[18] = 1'b0;
        s3_in = 1'b1;
        chk("n3_ack_out", 64'(a3_out), 64'd1);
        idle(1);
        s3_in = 1'b0;
        idle(1);
        chk("n3_err_pulse", 64'(err3), 64'd1);
        chk("n3_err_send", 64'(s3_out), 64'b001);
        chk("n3_err_pkt", 64'(p3_out), 64'(e3));
        idle(1);
        chk("n3_err_clear", 64'(err3), 64'd0);
        chk("n3_err_gone", 64'(s3_out), 64'd0);

        w3 = 1'b1; addr3 = 6'd10; data3 = 5'b00101;
        idle(1);
        w3 = 1'b0;
        p3_in = mkpkt(10, 1'b0);
        e3 = p3_in;
        e3[18] = 1'b1;
        s3_in = 1'b1;
        idle(1);
        s3_in = 1'b0;
        idle(1);
        chk("n3_p2_send", 64'(s3_out), 64'b100);
        chk("n3_p2_err", 64'(err3), 64'd0);
        chk("n3_p2_pkt", 64'(p3_out), 64'(e3));
        idle(1);
        chk("n3_p2_gone", 64'(s3_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
